// File: rtl/gpio_msg_rx.sv
// gpio_msg_rx: follower-side GPIO frame receiver.
// Checks sync/length/checksum, buffers the payload and replays good frames on a valid/ready stream.
module gpio_msg_rx #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 255
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] gpio_data_i,
  input  logic        gpio_valid_i,
  output logic [15:0] out_data_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        frame_ok_o,
  output logic        frame_err_o,
  output logic [1:0]  err_code_o,
  output logic        busy_o
);
  // state   | meaning
  // IDLE    | waiting for a strobed SYNC header
  // PAYLOAD | storing LEN payload words into the buffer
  // CHECK   | next strobed word is compared with the running sum
  // DRAIN   | replaying the buffered frame to local logic

  localparam int         PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [1:0] E_OVERRUN = 2'b00;
  localparam logic [1:0] E_LEN     = 2'b01;
  localparam logic [1:0] E_CSUM    = 2'b10;
  localparam logic [1:0] E_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [15:0]    gd_q;
  logic           gv_q;
  logic [15:0]    sum_q, sum_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  len_m1_q, len_m1_d;
  logic [7:0]     to_cnt_q, to_cnt_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           ok_d, err_d, mem_we;
  logic           hdr_seen, to_hit;
  logic [7:0]     hdr_len;
  logic [15:0]    mem_q [MAX_LEN];

  assign hdr_seen = gv_q && (gd_q[15:8] == SYNC);
  assign hdr_len  = gd_q[7:0];
  // The counter holds the number of low cycles already seen; this low cycle makes TIMEOUT.
  assign to_hit   = !gv_q && (to_cnt_q == TO_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      gd_q       <= '0;
      gv_q       <= 1'b0;
      sum_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_m1_q   <= '0;
      to_cnt_q   <= '0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      gd_q       <= gpio_data_i;
      gv_q       <= gpio_valid_i;
      sum_q      <= sum_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_m1_q   <= len_m1_d;
      to_cnt_q   <= to_cnt_d;
      err_code_q <= err_code_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= gd_q;
  end

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_m1_d    = len_m1_q;
    to_cnt_d    = to_cnt_q;
    err_code_d  = err_code_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    mem_we      = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    case (state_q)
      IDLE: begin
        if (hdr_seen) begin
          if (hdr_len == 8'd0 || hdr_len > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = E_LEN;
          end else begin
            len_m1_d = PW'(hdr_len - 8'd1);
            sum_d    = gd_q;
            wr_ptr_d = '0;
            to_cnt_d = '0;
            state_d  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (gv_q) begin
          mem_we   = 1'b1;
          sum_d    = sum_q + gd_q;
          to_cnt_d = '0;
          // Pointer parks on the last slot so a max-length frame never wraps.
          if (wr_ptr_q == len_m1_q) state_d = CHECK;
          else wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (to_hit) begin
          err_d      = 1'b1;
          err_code_d = E_TIMEOUT;
          state_d    = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      CHECK: begin
        if (gv_q) begin
          if (gd_q == sum_q) begin
            ok_d     = 1'b1;
            rd_ptr_d = '0;
            state_d  = DRAIN;
          end else begin
            err_d      = 1'b1;
            err_code_d = E_CSUM;
            state_d    = IDLE;
          end
        end else if (to_hit) begin
          err_d      = 1'b1;
          err_code_d = E_TIMEOUT;
          state_d    = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        out_valid_o = 1'b1;
        out_data_o  = mem_q[rd_ptr_q];
        out_last_o  = (rd_ptr_q == len_m1_q);
        if (hdr_seen) begin
          err_d      = 1'b1;
          err_code_d = E_OVERRUN;
        end
        if (out_ready_i) begin
          if (out_last_o) state_d = IDLE;
          else rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses are suppressed while reset is held so a discarded frame raises no flag.
  assign frame_ok_o  = ok_d & ~reset_i;
  assign frame_err_o = err_d & ~reset_i;
  assign err_code_o  = err_code_d;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_msg_rx.sv
// Bench for gpio_msg_rx: table vectors, hand-written corner sequences and
// randomized frames checked against a frame-level model of the receive rules.
module tb_gpio_msg_rx;
  localparam int MAX_LEN = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] gpio_data = '0;
  logic        gpio_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_valid, out_last, frame_ok, frame_err, busy;
  logic [1:0]  err_code;

  gpio_msg_rx #(.MAX_LEN(MAX_LEN), .SYNC(8'hA5), .TIMEOUT(255)) dut (
    .clock_i(clock), .reset_i(reset), .gpio_data_i(gpio_data), .gpio_valid_i(gpio_valid),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_last_o(out_last), .out_ready_i(out_ready),
    .frame_ok_o(frame_ok), .frame_err_o(frame_err), .err_code_o(err_code), .busy_o(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int              n;
    logic [19:0][15:0] w;
    int              eok;
    int              eerr;
    logic [1:0]      ecode;
    int              first_out;
    int              n_out;
  } vec_t;

  int          n_cmp = 0, n_bad = 0;
  int          ok_cnt = 0, err_cnt = 0;
  logic [1:0]  last_code = '0;
  logic [1:0]  model_code = '0;
  logic [15:0] got_d[$];
  logic        got_l[$];
  logic [15:0] tx_q[$];
  logic [15:0] exp_q[$];
  logic        ready_rand = 1'b0, ready_fix = 1'b1;
  int          max_gap = 0;
  logic        prev_stall = 1'b0, prev_last = 1'b0;
  logic [15:0] prev_data = '0;
  vec_t        tbl [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fix;
  end

  // Output monitor: pulse counting, stream capture and stall-hold checks.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_ok || frame_err) chk("ok_err_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
      if (frame_ok) ok_cnt++;
      if (frame_err) begin
        err_cnt++;
        last_code = err_code;
      end
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {16'd0, out_data}, {16'd0, prev_data});
        chk("hold_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] w);
    gpio_data  = w;
    gpio_valid = 1'b1;
    @(posedge clock);
    #1;
    gpio_valid = 1'b0;
    gpio_data  = 16'($urandom);
  endtask

  task automatic do_frame(input int eok, input int eerr, input logic [1:0] ecode, input string tag);
    int ok0, err0, k;
    ok0 = ok_cnt;
    err0 = err_cnt;
    got_d.delete();
    got_l.delete();
    foreach (tx_q[i]) begin
      send(tx_q[i]);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    idle(3);
    k = 0;
    while (busy && k < 3000) begin
      idle(1);
      k++;
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
    idle(1);
    chk({tag, "_ok"}, ok_cnt - ok0, eok);
    chk({tag, "_err"}, err_cnt - err0, eerr);
    if (eerr > 0) begin
      chk({tag, "_code"}, {30'd0, last_code}, {30'd0, ecode});
      model_code = ecode;
    end
    chk({tag, "_code_held"}, {30'd0, err_code}, {30'd0, model_code});
    chk({tag, "_nout"}, got_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
      chk({tag, "_data"}, {16'd0, got_d[i]}, {16'd0, exp_q[i]});
      chk({tag, "_last"}, {31'd0, got_l[i]}, {31'd0, (i == exp_q.size() - 1)});
    end
    chk({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
  endtask

  function automatic vec_t mk(input int n, input logic [15:0] a0, a1, a2, a3, a4, a5,
                              input int eok, input int eerr, input logic [1:0] ecode);
    vec_t v;
    v = '0;
    v.n = n;
    v.w[0] = a0; v.w[1] = a1; v.w[2] = a2; v.w[3] = a3; v.w[4] = a4; v.w[5] = a5;
    v.eok = eok;
    v.eerr = eerr;
    v.ecode = ecode;
    v.first_out = 1;
    v.n_out = (eok != 0) ? n - 2 : 0;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, kind, len, ok0, err0;
    logic [15:0] s, w;

    tbl[0] = mk(5, 16'hA503, 16'h0001, 16'h0002, 16'h0003, 16'hA509, 16'h0, 1, 0, 2'b00);
    tbl[1] = mk(5, 16'hA503, 16'h0001, 16'h0002, 16'h0003, 16'hA50A, 16'h0, 0, 1, 2'b10);
    tbl[2] = mk(1, 16'hA500, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 2'b01);
    tbl[3] = mk(1, 16'hA511, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 2'b01);
    tbl[4] = mk(2, 16'h1234, 16'h00A5, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 2'b00);
    tbl[5] = mk(18, 16'hA510, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 0, 2'b00);
    for (int i = 1; i <= 16; i++) tbl[5].w[i] = 16'(i);
    tbl[5].w[17] = 16'hA598;
    tbl[6] = mk(3, 16'hA501, 16'hFFFF, 16'hA500, 16'h0, 16'h0, 16'h0, 1, 0, 2'b00);
    tbl[7] = mk(4, 16'hA502, 16'h8000, 16'h8001, 16'hA503, 16'h0, 16'h0, 1, 0, 2'b00);
    tbl[8] = mk(1, 16'hA5FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1, 2'b01);
    // Bad checksum immediately followed by a good header: the header must be accepted.
    tbl[9] = mk(6, 16'hA501, 16'h0007, 16'hA509, 16'hA501, 16'h0003, 16'hA504, 1, 1, 2'b10);
    tbl[9].first_out = 4;
    tbl[9].n_out = 1;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_ok", {31'd0, frame_ok}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    idle(2);

    max_gap = 0;
    ready_fix = 1'b1;
    foreach (tbl[i]) begin
      tx_q.delete();
      exp_q.delete();
      for (int k = 0; k < tbl[i].n; k++) tx_q.push_back(tbl[i].w[k]);
      for (int k = 0; k < tbl[i].n_out; k++) exp_q.push_back(tbl[i].w[tbl[i].first_out + k]);
      do_frame(tbl[i].eok, tbl[i].eerr, tbl[i].ecode, $sformatf("vec%0d", i));
    end

    // Timeout: header + one payload of a 2-word frame, then the strobe stays low.
    send(16'hA502);
    send(16'h1234);
    n = 0;
    while (n < 400) begin
      @(negedge clock);
      n++;
      if (frame_err) break;
    end
    chk("timeout_cycle", n, 256);
    chk("timeout_code", {30'd0, err_code}, 32'd3);
    model_code = 2'b11;
    @(posedge clock);
    #1;
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    tx_q = '{16'hA501, 16'h0005, 16'hA506};
    exp_q = '{16'h0005};
    do_frame(1, 0, 2'b00, "after_timeout");

    // Overrun: a header arrives while the drain is stalled.
    ready_fix = 1'b0;
    idle(2);
    got_d.delete();
    got_l.delete();
    ok0 = ok_cnt;
    err0 = err_cnt;
    send(16'hA502);
    send(16'h0011);
    send(16'h0022);
    send(16'hA535);
    n = 0;
    while (!out_valid && n < 50) begin
      idle(1);
      n++;
    end
    chk("ovr_drain_start", {31'd0, out_valid}, 32'd1);
    send(16'hA501);
    idle(3);
    chk("ovr_err_cnt", err_cnt - err0, 1);
    chk("ovr_code", {30'd0, last_code}, 32'd0);
    chk("ovr_code_held", {30'd0, err_code}, 32'd0);
    model_code = 2'b00;
    chk("ovr_valid_held", {31'd0, out_valid}, 32'd1);
    chk("ovr_data_held", {16'd0, out_data}, 32'h0011);
    chk("ovr_ok_cnt", ok_cnt - ok0, 1);
    ready_fix = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("ovr_done", {31'd0, busy}, 32'd0);
    chk("ovr_nout", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("ovr_d0", {16'd0, got_d[0]}, 32'h0011);
      chk("ovr_d1", {16'd0, got_d[1]}, 32'h0022);
      chk("ovr_l0", {31'd0, got_l[0]}, 32'd0);
      chk("ovr_l1", {31'd0, got_l[1]}, 32'd1);
    end
    chk("ovr_err_final", err_cnt - err0, 1);

    // Reset in the middle of a payload.
    send(16'hA503);
    send(16'h0001);
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_data", {16'd0, out_data}, 32'd0);
    chk("rst_mid_last", {31'd0, out_last}, 32'd0);
    chk("rst_mid_ok", {31'd0, frame_ok}, 32'd0);
    chk("rst_mid_err", {31'd0, frame_err}, 32'd0);
    chk("rst_mid_code", {30'd0, err_code}, 32'd0);
    model_code = 2'b00;
    tx_q = '{16'hA501, 16'hFFFF, 16'hA500};
    exp_q = '{16'hFFFF};
    do_frame(1, 0, 2'b00, "after_reset");

    // Randomized frames against the frame-level rules.
    ready_rand = 1'b1;
    max_gap = 2;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      tx_q.delete();
      exp_q.delete();
      if (kind <= 7) begin
        len = $urandom_range(1, MAX_LEN);
        w = {8'hA5, 8'(len)};
        s = w;
        tx_q.push_back(w);
        for (int k = 0; k < len; k++) begin
          w = 16'($urandom);
          s = s + w;
          tx_q.push_back(w);
          if (kind <= 5) exp_q.push_back(w);
        end
        if (kind <= 5) begin
          tx_q.push_back(s);
          do_frame(1, 0, 2'b00, "rnd_good");
        end else begin
          tx_q.push_back(s + 16'($urandom_range(1, 65535)));
          do_frame(0, 1, 2'b10, "rnd_badsum");
        end
      end else if (kind == 8) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        tx_q.push_back({8'hA5, 8'(len)});
        do_frame(0, 1, 2'b01, "rnd_badlen");
      end else begin
        w = 16'($urandom);
        if (w[15:8] == 8'hA5) w[15:8] = 8'h5A;
        tx_q.push_back(w);
        do_frame(0, 0, 2'b00, "rnd_junk");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
